multi_door_flasher: RTL

MULTI_DOOR_FLASHER -- requirements
Module: multi_door_flasher

---
 rtl/multi_door_flasher.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multi_door_flasher.sv
// Per-door flash sequencer: each door channel arms on a trigger rising edge and
// flashes its LED on a shared slow tick. Optional retrigger: DOOR_RETRIGGER_EN.
module multi_door_flasher #(
    parameter int NUM_DOORS   = 4,
    parameter int FLASH_COUNT = 20,
    parameter int TICK_DIV    = 20000000
) (
    input  logic                 clk_40MHz,
    input  logic                 reset,
    input  logic [NUM_DOORS-1:0] trigger,
    output logic [NUM_DOORS-1:0] LED,
    output logic [NUM_DOORS-1:0] busy,
    output logic [NUM_DOORS-1:0] done
);

    localparam int CNT_W = $clog2(FLASH_COUNT + 1);
    localparam int DIV_W = $clog2(TICK_DIV);
    // The start tick is the first of the FLASH_COUNT ticks, so the counter
    // holds the ticks still to come after it.
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(FLASH_COUNT - 1);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLASH = 2'd2
    } state_t;

    logic [NUM_DOORS-1:0] trig_q;
    logic [NUM_DOORS-1:0] rise;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;

    state_t               state_q [NUM_DOORS];
    state_t               state_d [NUM_DOORS];
    logic [CNT_W-1:0]     cnt_q   [NUM_DOORS];
    logic [CNT_W-1:0]     cnt_d   [NUM_DOORS];
    logic [NUM_DOORS-1:0] led_q, led_d;
    logic [NUM_DOORS-1:0] busy_q, busy_d;
    logic [NUM_DOORS-1:0] done_q, done_d;
`ifdef DOOR_RETRIGGER_EN
    logic [NUM_DOORS-1:0] retrig_q, retrig_d;
`endif

    assign rise = trigger & ~trig_q;
    assign tick = (div_q == DIV_MAX);

    // Shared prescaler next value.
    always_comb begin
        div_d = div_q;
        if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Per-channel sequencer next state and outputs.
    always_comb begin
        for (int i = 0; i < NUM_DOORS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            led_d[i]   = led_q[i];
            done_d[i]  = 1'b0;
`ifdef DOOR_RETRIGGER_EN
            retrig_d[i] = 1'b0;
`endif
            case (state_q[i])
                IDLE: begin
                    led_d[i] = 1'b0;
                    cnt_d[i] = '0;
                    if (rise[i]) begin
                        state_d[i] = ARMED;
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        led_d[i]   = 1'b1;
                        cnt_d[i]   = START_CNT;
                        state_d[i] = FLASH;
                    end else begin
                        state_d[i] = ARMED;
                    end
                end
                FLASH: begin
`ifdef DOOR_RETRIGGER_EN
                    if (tick) begin
                        retrig_d[i] = rise[i];
                        if (retrig_q[i]) begin
                            cnt_d[i] = START_CNT;
                            led_d[i] = ~led_q[i];
                        end else if (cnt_q[i] > CNT_W'(1)) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i]   = '0;
                            led_d[i]   = 1'b0;
                            done_d[i]  = 1'b1;
                            state_d[i] = IDLE;
                        end
                    end else begin
                        retrig_d[i] = retrig_q[i] | rise[i];
                    end
`else
                    if (tick) begin
                        if (cnt_q[i] > CNT_W'(1)) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i]   = '0;
                            led_d[i]   = 1'b0;
                            done_d[i]  = 1'b1;
                            state_d[i] = IDLE;
                        end
                    end else begin
                        state_d[i] = FLASH;
                    end
`endif
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                    led_d[i]   = 1'b0;
                end
            endcase
            busy_d[i] = (state_d[i] != IDLE);
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk_40MHz) begin
        if (reset) begin
            trig_q <= '0;
            div_q  <= '0;
            led_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
`ifdef DOOR_RETRIGGER_EN
            retrig_q <= '0;
`endif
            for (int i = 0; i < NUM_DOORS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            trig_q <= trigger;
            div_q  <= div_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef DOOR_RETRIGGER_EN
            retrig_q <= retrig_d;
`endif
            for (int i = 0; i < NUM_DOORS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
